// File: rtl/wb_riot.sv
// 6532 RIOT as a Wishbone slave: 128 B RAM, two I/O ports, interval timer, PA7 edge detect.
// Every side effect is qualified by cpu_en_i so a long-held bus access acts once per CPU cycle.
module wb_riot #(
  parameter int WB_ADDR_WIDTH = 16,
  parameter int WB_DATA_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cpu_en_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic                     ack_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [7:0]               pa_i,
  output logic [7:0]               pa_o,
  output logic [7:0]               pa_oe,
  input  logic [7:0]               pb_i,
  output logic [7:0]               pb_o,
  output logic [7:0]               pb_oe,
  output logic                     irq_o
);

  logic [7:0] ram [0:127];
  logic [7:0] ora, ddra, orb, ddrb, timer, rd_data;
  logic [9:0] prescaler, reload;
  logic [1:0] iv_sel;
  logic       underflowed, timflg, pa7flg, tim_ie, pa7_ie, edge_pos, pa7_q;
  logic       act, wr, rd, ram_we, io_we, tim_load, edge_we, rd_intim, rd_timint;
  logic       tick_dec, wrap, pa7_edge;
  logic       unused_adr;

  assign unused_adr = ^{adr_i[WB_ADDR_WIDTH-1:10], adr_i[8:7], adr_i[5]};

  function automatic logic [9:0] reload_of(input logic [1:0] s);
    case (s)
      2'd0:    return 10'd0;
      2'd1:    return 10'd7;
      2'd2:    return 10'd63;
      default: return 10'd1023;
    endcase
  endfunction

  assign act       = stb_i & cpu_en_i;
  assign wr        = act & we_i;
  assign rd        = act & ~we_i;
  assign ram_we    = wr & ~adr_i[9];
  assign io_we     = wr & adr_i[9] & ~adr_i[2];
  assign tim_load  = wr & adr_i[9] & adr_i[2] & adr_i[4];
  assign edge_we   = wr & adr_i[9] & adr_i[2] & ~adr_i[4];
  assign rd_intim  = rd & adr_i[9] & adr_i[2] & ~adr_i[0];
  assign rd_timint = rd & adr_i[9] & adr_i[2] & adr_i[0];

  assign reload   = reload_of(iv_sel);
  // once underflowed the prescaler is bypassed: decrement on every tick
  assign tick_dec = underflowed | (prescaler == 10'd0);
  assign wrap     = tick_dec & (timer == 8'd0);
  assign pa7_edge = cpu_en_i & (edge_pos ? (~pa7_q & pa_i[7]) : (pa7_q & ~pa_i[7]));

  assign pa_o  = ora;
  assign pa_oe = ddra;
  assign pb_o  = orb;
  assign pb_oe = ddrb;

  always_comb begin
    rd_data = 8'h00;
    if (!adr_i[9])
      rd_data = ram[adr_i[6:0]];
    else if (!adr_i[2]) begin
      case (adr_i[1:0])
        2'd0:    rd_data = (pa_i & ~ddra) | (ora & ddra);
        2'd1:    rd_data = ddra;
        2'd2:    rd_data = (pb_i & ~ddrb) | (orb & ddrb);
        default: rd_data = ddrb;
      endcase
    end else if (adr_i[0])
      rd_data = {timflg, pa7flg, 6'b0};
    else
      rd_data = timer;
  end

  always_ff @(posedge clk_i)
    if (!rst_i && ram_we) ram[adr_i[6:0]] <= dat_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o       <= 1'b0;
      dat_o       <= '0;
      irq_o       <= 1'b0;
      ora         <= 8'h00;
      ddra        <= 8'h00;
      orb         <= 8'h00;
      ddrb        <= 8'h00;
      timer       <= 8'h00;
      iv_sel      <= 2'd3;
      prescaler   <= 10'd1023;
      underflowed <= 1'b0;
      timflg      <= 1'b0;
      pa7flg      <= 1'b0;
      tim_ie      <= 1'b0;
      pa7_ie      <= 1'b0;
      edge_pos    <= 1'b0;
      pa7_q       <= 1'b0;
    end else begin
      ack_o <= stb_i;
      dat_o <= rd_data;
      irq_o <= (timflg & tim_ie) | (pa7flg & pa7_ie);

      if (io_we) begin
        case (adr_i[1:0])
          2'd0:    ora  <= dat_i;
          2'd1:    ddra <= dat_i;
          2'd2:    orb  <= dat_i;
          default: ddrb <= dat_i;
        endcase
      end

      if (edge_we) begin
        edge_pos <= adr_i[0];
        pa7_ie   <= adr_i[1];
      end

      if (cpu_en_i) begin
        pa7_q <= pa_i[7];
        if (tim_load) begin
          timer       <= dat_i;
          iv_sel      <= adr_i[1:0];
          prescaler   <= reload_of(adr_i[1:0]);
          underflowed <= 1'b0;
          timflg      <= 1'b0;
          tim_ie      <= adr_i[3];
        end else begin
          if (tick_dec) begin
            timer <= timer - 8'd1;
            if (!underflowed) prescaler <= reload;
          end else
            prescaler <= prescaler - 10'd1;
          // underflow beats a simultaneous INTIM read
          if (wrap) begin
            timflg      <= 1'b1;
            underflowed <= 1'b1;
          end else if (rd_intim) begin
            timflg      <= 1'b0;
            underflowed <= 1'b0;
          end
          if (rd_intim) begin
            tim_ie    <= adr_i[3];
            prescaler <= reload;
          end
        end
        if (pa7_edge)       pa7flg <= 1'b1;
        else if (rd_timint) pa7flg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_riot.sv
// Bench for wb_riot: directed vector table, hand sequences for timer/edge/reset, then
// randomized traffic checked against a cycle-level behavioural model.
module tb_wb_riot;

  logic        clk = 1'b0, rst = 1'b0, cpu_en = 1'b0, stb = 1'b0, we = 1'b0;
  logic [15:0] adr = '0;
  logic [7:0]  dat = '0, pa = '0, pb = '0;
  logic        ack, irq;
  logic [7:0]  dout, pa_o, pa_oe, pb_o, pb_oe;
  int          vecs = 0, miss = 0;

  wb_riot dut (
    .clk_i(clk), .rst_i(rst), .cpu_en_i(cpu_en), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(dat), .ack_o(ack), .dat_o(dout),
    .pa_i(pa), .pa_o(pa_o), .pa_oe(pa_oe), .pb_i(pb), .pb_o(pb_o), .pb_oe(pb_oe),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic s, w, e, input logic [15:0] a, input logic [7:0] d);
    stb = s; we = w; cpu_en = e; adr = a; dat = d;
  endtask

  task automatic tick_en();
    cpu_en = 1'b1; cyc();
    cpu_en = 1'b0; cyc();
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        s, w, e;
    logic [15:0] a;
    logic [7:0]  d, pa, pb;
    logic        chk_dat;
    logic [7:0]  exp_dat;
  } vec_t;

  // behavioural model state
  logic [7:0] m_ram [128];
  bit         m_rv  [128];
  logic [7:0] m_ora, m_ddra, m_orb, m_ddrb, m_timer;
  int         m_per, m_cnt;
  bit         m_uf, m_tflg, m_pflg, m_tie, m_pie, m_epos, m_pa7;

  task automatic model_reset();
    m_ora = 0; m_ddra = 0; m_orb = 0; m_ddrb = 0; m_timer = 0;
    m_per = 1024; m_cnt = 1023;
    m_uf = 0; m_tflg = 0; m_pflg = 0; m_tie = 0; m_pie = 0; m_epos = 0; m_pa7 = 0;
    foreach (m_rv[i]) m_rv[i] = 0;
  endtask

  // One clock of the model: returns what DUT registers at this edge, then advances state.
  task automatic model_step(output logic [7:0] rdv, output bit known, output bit eirq);
    logic [9:0] a;
    bit act, wrap, edge_seen;
    a = adr[9:0];
    act = stb && cpu_en;
    known = 1;
    if (!a[9]) begin
      rdv = m_ram[a[6:0]]; known = m_rv[a[6:0]];
    end else if (!a[2]) begin
      case (a[1:0])
        0: rdv = (pa & ~m_ddra) | (m_ora & m_ddra);
        1: rdv = m_ddra;
        2: rdv = (pb & ~m_ddrb) | (m_orb & m_ddrb);
        default: rdv = m_ddrb;
      endcase
    end else if (a[0]) rdv = {m_tflg, m_pflg, 6'b0};
    else rdv = m_timer;
    eirq = (m_tflg && m_tie) || (m_pflg && m_pie);

    if (act && we && !a[9]) begin m_ram[a[6:0]] = dat; m_rv[a[6:0]] = 1; end
    if (act && we && a[9] && !a[2])
      case (a[1:0]) 0: m_ora = dat; 1: m_ddra = dat; 2: m_orb = dat; default: m_ddrb = dat; endcase
    if (cpu_en) begin
      edge_seen = m_epos ? (!m_pa7 && pa[7]) : (m_pa7 && !pa[7]);
      if (act && we && a[9] && a[2] && a[4]) begin
        m_timer = dat;
        m_per = (a[1:0] == 3) ? 1024 : (1 << (3 * a[1:0]));
        m_cnt = m_per - 1; m_uf = 0; m_tflg = 0; m_tie = a[3];
      end else begin
        wrap = 0;
        if (m_uf || m_cnt == 0) begin
          wrap = (m_timer == 0);
          m_timer = m_timer - 1;
          m_cnt = m_per - 1;
        end else m_cnt--;
        if (wrap) begin m_tflg = 1; m_uf = 1; end
        if (act && !we && a[9] && a[2] && !a[0]) begin
          m_tie = a[3]; m_cnt = m_per - 1;
          if (!wrap) begin m_tflg = 0; m_uf = 0; end
        end
      end
      if (edge_seen) m_pflg = 1;
      else if (act && !we && a[9] && a[2] && a[0]) m_pflg = 0;
      m_pa7 = pa[7];
    end
    if (act && we && a[9] && a[2] && !a[4]) begin m_epos = a[0]; m_pie = a[1]; end
  endtask

  vec_t tbl[$];

  initial begin
    logic [7:0] rdv;
    bit known, eirq;
    logic [41:0] got, exp;

    // reset state
    rst = 1'b1; cyc(); cyc();
    chk("reset_outputs", {ack, irq, dout, pa_o, pa_oe, pb_o, pb_oe}, 42'h0);
    rst = 1'b0;

    tbl = '{
      '{1,1,1,16'h0080,8'h5A,8'h00,8'h00,0,8'h00},
      '{1,1,1,16'h00FF,8'h3C,8'h00,8'h00,0,8'h00},
      '{1,0,0,16'h0080,8'h00,8'h00,8'h00,1,8'h5A},
      '{1,0,0,16'h00FF,8'h00,8'h00,8'h00,1,8'h3C},
      '{0,0,0,16'h0080,8'h00,8'h00,8'h00,1,8'h5A},
      '{1,1,1,16'h0281,8'hF0,8'h3C,8'h00,0,8'h00},
      '{1,1,1,16'h0280,8'hA5,8'h3C,8'h00,0,8'h00},
      '{1,0,0,16'h0280,8'h00,8'h3C,8'h00,1,8'hAC},
      '{1,1,1,16'h0283,8'h0F,8'h3C,8'hF0,0,8'h00},
      '{1,1,1,16'h0282,8'h66,8'h3C,8'hF0,0,8'h00},
      '{1,0,0,16'h0282,8'h00,8'h3C,8'hF0,1,8'hF6},
      '{1,1,0,16'h0280,8'hFF,8'h3C,8'hF0,0,8'h00},
      '{1,0,0,16'h0280,8'h00,8'h3C,8'hF0,1,8'hAC},
      '{1,0,0,16'hFC80,8'h00,8'h3C,8'hF0,1,8'h5A}
    };
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].w, tbl[i].e, tbl[i].a, tbl[i].d);
      pa = tbl[i].pa; pb = tbl[i].pb;
      cyc();
      chk($sformatf("tbl%0d_ack", i), ack, tbl[i].s);
      if (tbl[i].chk_dat) chk($sformatf("tbl%0d_dat", i), dout, tbl[i].exp_dat);
    end
    chk("port_regs", {pa_o, pa_oe, pb_o, pb_oe}, 32'hA5F0_660F);

    // TIM8T load of 3, countdown through underflow
    drive(1, 1, 1, 16'h0295, 8'h03); cyc();
    drive(0, 0, 0, 16'h0284, 8'h00);
    for (int k = 1; k <= 33; k++) begin
      tick_en();
      chk($sformatf("tim8_k%0d", k), dout, (k < 32) ? 8'(3 - k / 8) : (k == 32 ? 8'hFF : 8'hFE));
    end
    adr = 16'h0285; cyc();
    chk("timint_uf", dout, 8'h80);
    drive(1, 0, 1, 16'h0284, 8'h00); cyc();
    drive(0, 0, 0, 16'h0284, 8'h00); cyc();
    chk("intim_rd_act", dout, 8'hFD);
    adr = 16'h0285; cyc();
    chk("timint_cleared", dout, 8'h00);
    adr = 16'h0284;
    for (int k = 1; k <= 7; k++) tick_en();
    chk("interval_restored_hold", dout, 8'hFD);
    tick_en();
    chk("interval_restored_dec", dout, 8'hFC);

    // load on the exact underflow tick suppresses the flag
    drive(1, 1, 1, 16'h0294, 8'h01); cyc();
    drive(0, 0, 0, 16'h0284, 8'h00); tick_en();
    chk("tim1_at_zero", dout, 8'h00);
    drive(1, 1, 1, 16'h0294, 8'h05); cyc();
    drive(0, 0, 0, 16'h0285, 8'h00); cyc(); cyc();
    chk("load_vs_uf_flag", dout, 8'h00);
    adr = 16'h0284; cyc();
    chk("load_vs_uf_val", dout, 8'h05);

    // held strobe with a single cpu_en pulse
    drive(1, 1, 0, 16'h0294, 8'h10);
    for (int i = 0; i < 16; i++) begin cpu_en = (i == 5); cyc(); end
    drive(0, 0, 0, 16'h0284, 8'h00); cyc(); cyc();
    chk("held_load", dout, 8'h10);
    tick_en();
    chk("held_load_tick", dout, 8'h0F);

    // PA7 positive edge with IRQ enable
    pa = 8'h00;
    drive(1, 1, 1, 16'h0287, 8'h00); cyc();
    drive(0, 0, 0, 16'h0285, 8'h00); tick_en();
    chk("no_edge_yet", {irq, dout}, 9'h000);
    pa = 8'h80; tick_en();
    chk("pa7_flag", dout, 8'h40);
    cyc();
    chk("pa7_irq", irq, 1'b1);
    drive(1, 0, 1, 16'h0285, 8'h00); cyc();
    drive(0, 0, 0, 16'h0285, 8'h00); cyc(); cyc();
    chk("pa7_clear", {irq, dout}, 9'h000);

    // reset mid-count with a write pending
    drive(1, 1, 1, 16'h0296, 8'h50); cyc();
    drive(0, 0, 0, 16'h0284, 8'h00);
    for (int i = 0; i < 3; i++) tick_en();
    rst = 1'b1; drive(1, 1, 1, 16'h0281, 8'h77); cyc();
    chk("midreset_outputs", {ack, irq, dout, pa_o, pa_oe, pb_o, pb_oe}, 42'h0);
    rst = 1'b0; drive(0, 0, 0, 16'h0284, 8'h00); cyc();
    chk("midreset_timer", dout, 8'h00);
    adr = 16'h0285; cyc();
    chk("midreset_timint", dout, 8'h00);
    adr = 16'h0281; cyc();
    chk("midreset_ddra", dout, 8'h00);

    // randomized traffic vs model
    rst = 1'b1; drive(0, 0, 0, 16'h0000, 8'h00); pa = 0; pb = 0; cyc();
    rst = 1'b0; model_reset();
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
            {6'($urandom), 1'($urandom), 9'($urandom)},
            $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom));
      pa = 8'($urandom); pb = 8'($urandom);
      model_step(rdv, known, eirq);
      cyc();
      exp = {rdv, stb_prev(), eirq, m_ora, m_ddra, m_orb, m_ddrb};
      got = {known ? dout : rdv, ack, irq, pa_o, pa_oe, pb_o, pb_oe};
      chk($sformatf("rand%0d", n), got, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  // strobe value that was sampled at the last edge (inputs are not changed until after the check)
  function automatic logic stb_prev();
    return stb;
  endfunction

endmodule
